ext_trigger_out: RTL and testbench

EXT_TRIGGER_OUT -- requirements
Module: ext_trigger_out

---
 rtl/ext_trigger_out_if.sv | 29 ++
 rtl/ext_trigger_out.sv | 169 ++++++++++++++++
 tb/tb_ext_trigger_out.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_trigger_out_if.sv
// Signal bundle for ext_trigger_out: S-bit ORs, per-output configuration,
// shared trigger controls and the external trigger/counter outputs.
interface ext_trigger_out_if #(
   parameter int unsigned NUM_VFATS   = 24,
   parameter int unsigned NUM_OUTPUTS = 8,
   parameter int unsigned CNT_W       = 16
);
   logic [NUM_VFATS-1:0]         active_vfats_i;
   logic [3*NUM_OUTPUTS-1:0]     sbit_mode_i;
   logic [5*NUM_OUTPUTS-1:0]     sbit_sel_i;
   logic [4*NUM_OUTPUTS-1:0]     stretch_i;
   logic [4:0]                   mult_thresh_i;
   logic [15:0]                  pulse_period_i;
   logic                         cnt_reset_i;
   logic [NUM_OUTPUTS-1:0]       ext_sbits_o;
   logic [CNT_W*NUM_OUTPUTS-1:0] ext_cnt_o;

   modport master (
      output active_vfats_i, sbit_mode_i, sbit_sel_i, stretch_i,
             mult_thresh_i, pulse_period_i, cnt_reset_i,
      input  ext_sbits_o, ext_cnt_o
   );

   modport slave (
      input  active_vfats_i, sbit_mode_i, sbit_sel_i, stretch_i,
             mult_thresh_i, pulse_period_i, cnt_reset_i,
      output ext_sbits_o, ext_cnt_o
   );
endinterface

// File: rtl/ext_trigger_out.sv
// External trigger output block: three-stage S-bit pipeline selecting a raw
// trigger per output, a shared test-pulse generator, and per-output
// non-retriggerable pulse stretchers with saturating accepted-pulse counters.
module ext_trigger_out #(
   parameter int unsigned NUM_VFATS   = 24,
   parameter int unsigned NUM_ETA     = 8,
   parameter int unsigned NUM_SECTORS = 6,
   parameter int unsigned NUM_OUTPUTS = 8,
   parameter int unsigned CNT_W       = 16
) (
   input logic              clock,
   input logic              reset_n_i,
   ext_trigger_out_if.slave bus
);
   localparam int unsigned SECT_W = NUM_VFATS / NUM_SECTORS;

   typedef enum logic {IDLE, HIGH} stretch_t;

   logic [NUM_VFATS-1:0]   ors, ors_d;
   logic [NUM_ETA-1:0]     eta, eta_nx;
   logic [NUM_SECTORS-1:0] sector, sector_nx;
   logic                   mult, mult_nx;
   logic [5:0]             pop;
   logic [31:0]            ors_ext, eta_ext, sector_ext;
   logic [15:0]            tp_cnt;
   logic                   tp_strobe;
   logic [NUM_OUTPUTS-1:0] raw, raw_nx, raw_q, rise;
   logic [2:0]             mode_k;
   logic [4:0]             sel_k;
   stretch_t               state    [NUM_OUTPUTS];
   stretch_t               state_nx [NUM_OUTPUTS];
   logic [3:0]             dn       [NUM_OUTPUTS];
   logic [3:0]             dn_nx    [NUM_OUTPUTS];
   logic [CNT_W-1:0]       cnt      [NUM_OUTPUTS];
   logic [CNT_W-1:0]       cnt_nx   [NUM_OUTPUTS];
   logic [NUM_OUTPUTS-1:0]       sbits_v;
   logic [CNT_W*NUM_OUTPUTS-1:0] cnt_v;

   // Eta/sector reductions and multiplicity of the registered ORs.
   always_comb begin
      eta_nx    = '0;
      sector_nx = '0;
      pop       = '0;
      for (int unsigned i = 0; i < NUM_VFATS; i++) begin
         eta_nx[i % NUM_ETA]   = eta_nx[i % NUM_ETA] | ors[i];
         sector_nx[i / SECT_W] = sector_nx[i / SECT_W] | ors[i];
         pop = pop + 6'(ors[i]);
      end
      mult_nx = (bus.mult_thresh_i != '0) && ({1'b0, bus.mult_thresh_i} <= pop);
   end

   // Zero-extended to 32 so any 5-bit select beyond the real width reads 0.
   assign ors_ext    = 32'(ors_d);
   assign eta_ext    = 32'(eta);
   assign sector_ext = 32'(sector);

   assign tp_strobe = (bus.pulse_period_i != '0) && (tp_cnt == bus.pulse_period_i);

   // Per-output raw trigger source selection.
   always_comb begin
      raw_nx = '0;
      mode_k = '0;
      sel_k  = '0;
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
         mode_k = bus.sbit_mode_i[3*k +: 3];
         sel_k  = bus.sbit_sel_i[5*k +: 5];
         case (mode_k)
            3'd0:    raw_nx[k] = ors_ext[sel_k];
            3'd1:    raw_nx[k] = eta_ext[sel_k];
            3'd2:    raw_nx[k] = sector_ext[sel_k];
            3'd3:    raw_nx[k] = |ors_d;
            3'd4:    raw_nx[k] = mult;
            3'd5:    raw_nx[k] = tp_strobe;
            3'd6:    raw_nx[k] = 1'b0;
            default: raw_nx[k] = 1'b1;
         endcase
      end
   end

   // Input, derived-signal and raw pipeline stages.
   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ors    <= '0;
         ors_d  <= '0;
         eta    <= '0;
         sector <= '0;
         mult   <= 1'b0;
         raw    <= '0;
         raw_q  <= '0;
      end else begin
         ors    <= bus.active_vfats_i;
         ors_d  <= ors;
         eta    <= eta_nx;
         sector <= sector_nx;
         mult   <= mult_nx;
         raw    <= raw_nx;
         raw_q  <= raw;
      end
   end

   // Free-running test-pulse counter, wrapping after it matches the period.
   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i)
         tp_cnt <= '0;
      else if ((bus.pulse_period_i == '0) || tp_strobe)
         tp_cnt <= '0;
      else
         tp_cnt <= tp_cnt + 16'd1;
   end

   assign rise = raw & ~raw_q;

   // Stretcher next state; edges arriving while HIGH are neither stretched nor counted.
   always_comb begin
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
         state_nx[k] = state[k];
         dn_nx[k]    = dn[k];
         cnt_nx[k]   = cnt[k];
         case (state[k])
            IDLE: begin
               if (rise[k]) begin
                  state_nx[k] = HIGH;
                  dn_nx[k]    = bus.stretch_i[4*k +: 4];
                  if (cnt[k] != '1)
                     cnt_nx[k] = cnt[k] + CNT_W'(1);
               end
            end
            default: begin
               if (dn[k] == '0)
                  state_nx[k] = IDLE;
               else
                  dn_nx[k] = dn[k] - 4'd1;
            end
         endcase
         if (bus.cnt_reset_i)
            cnt_nx[k] = '0;
      end
   end

   // Stretcher state, down-counter and accepted-pulse counter registers.
   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
            state[k] <= IDLE;
            dn[k]    <= '0;
            cnt[k]   <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
            state[k] <= state_nx[k];
            dn[k]    <= dn_nx[k];
            cnt[k]   <= cnt_nx[k];
         end
      end
   end

   // Outputs come straight from the stretcher and counter registers.
   always_comb begin
      sbits_v = '0;
      cnt_v   = '0;
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
         sbits_v[k]              = (state[k] == HIGH);
         cnt_v[CNT_W*k +: CNT_W] = cnt[k];
      end
   end

   assign bus.ext_sbits_o = sbits_v;
   assign bus.ext_cnt_o   = cnt_v;
endmodule

// File: tb/tb_ext_trigger_out.sv
// Self-checking bench for ext_trigger_out: a timeline model of the trigger
// rules checked every cycle, plus directed scenarios with literal expectations.
module tb_ext_trigger_out;
   localparam int NV   = 24;
   localparam int NE   = 8;
   localparam int NS   = 6;
   localparam int NO   = 8;
   localparam int CW   = 8;
   localparam int SW   = NV / NS;
   localparam int CMAX = (1 << CW) - 1;

   logic clock;
   logic reset_n_i;
   int   checks = 0;
   int   errors = 0;

   ext_trigger_out_if #(.NUM_VFATS(NV), .NUM_OUTPUTS(NO), .CNT_W(CW)) bus ();

   ext_trigger_out #(
      .NUM_VFATS(NV), .NUM_ETA(NE), .NUM_SECTORS(NS), .NUM_OUTPUTS(NO), .CNT_W(CW)
   ) dut (
      .clock(clock),
      .reset_n_i(reset_n_i),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [NV-1:0] hv1, hv2;   // S-bit inputs seen one and two edges ago
   logic [4:0]    th1;        // threshold seen one edge ago
   logic [NO-1:0] r1, r2;     // raw trigger decided one and two edges ago
   int            m_tp;
   int            m_left [NO];
   int            m_cnt  [NO];

   function automatic logic raw_rule(input int mode, input int sel,
                                     input logic [NV-1:0] v, input int th, input logic tp);
      logic acc;
      acc = 1'b0;
      case (mode)
         0: if (sel < NV) acc = v[sel];
         1: if (sel < NE) for (int m = 0; m < NV / NE; m++) acc = acc | v[sel + m*NE];
         2: if (sel < NS) for (int i = 0; i < SW; i++) acc = acc | v[sel*SW + i];
         3: acc = |v;
         4: acc = (th != 0) && ($countones(v) >= th);
         5: acc = tp;
         6: acc = 1'b0;
         default: acc = 1'b1;
      endcase
      return acc;
   endfunction

   task automatic m_reset();
      hv1 = '0; hv2 = '0; th1 = '0; r1 = '0; r2 = '0; m_tp = 0;
      for (int k = 0; k < NO; k++) begin
         m_left[k] = 0;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic m_step();
      logic [NO-1:0] rnew;
      logic          tp_now;
      for (int k = 0; k < NO; k++) begin
         if (m_left[k] > 0)
            m_left[k]--;
         else if (r1[k] && !r2[k]) begin
            m_left[k] = int'(bus.stretch_i[4*k +: 4]) + 1;
            if (m_cnt[k] < CMAX) m_cnt[k]++;
         end
         if (bus.cnt_reset_i) m_cnt[k] = 0;
      end
      tp_now = (bus.pulse_period_i != 16'd0) && (m_tp == int'(bus.pulse_period_i));
      rnew = '0;
      for (int k = 0; k < NO; k++)
         rnew[k] = raw_rule(int'(bus.sbit_mode_i[3*k +: 3]), int'(bus.sbit_sel_i[5*k +: 5]),
                            hv2, int'(th1), tp_now);
      r2 = r1;
      r1 = rnew;
      if (bus.pulse_period_i == 16'd0 || tp_now) m_tp = 0;
      else m_tp++;
      hv2 = hv1;
      hv1 = bus.active_vfats_i;
      th1 = bus.mult_thresh_i;
   endtask

   initial begin : model
      m_reset();
      forever begin
         @(posedge clock or negedge reset_n_i);
         if (!reset_n_i) m_reset();
         else m_step();
      end
   end

   // Per-cycle comparison of both outputs against the model.
   initial begin : compare
      logic [NO-1:0]    exp_s;
      logic [CW*NO-1:0] exp_c;
      forever begin
         @(negedge clock);
         exp_s = '0;
         exp_c = '0;
         for (int k = 0; k < NO; k++) begin
            exp_s[k]         = (m_left[k] > 0);
            exp_c[CW*k +: CW] = CW'(m_cnt[k]);
         end
         checks++;
         if (bus.ext_sbits_o !== exp_s) begin
            errors++;
            $display("FAIL model_sbits t=%0t got %h expected %h", $time, bus.ext_sbits_o, exp_s);
         end
         checks++;
         if (bus.ext_cnt_o !== exp_c) begin
            errors++;
            $display("FAIL model_cnt t=%0t got %h expected %h", $time, bus.ext_cnt_o, exp_c);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic int cnt_of(input int k);
      return int'(bus.ext_cnt_o[CW*k +: CW]);
   endfunction

   function automatic logic [NV-1:0] vb(input int i);
      logic [NV-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_chan(input int k, input int mode, input int sel, input int st);
      bus.sbit_mode_i[3*k +: 3] = 3'(mode);
      bus.sbit_sel_i[5*k +: 5]  = 5'(sel);
      bus.stretch_i[4*k +: 4]   = 4'(st);
   endtask

   task automatic quiet();
      bus.active_vfats_i = '0;
      for (int k = 0; k < NO; k++) set_chan(k, 6, 0, 0);
      tick(6);
   endtask

   task automatic clear_cnt();
      bus.cnt_reset_i = 1'b1;
      tick(1);
      bus.cnt_reset_i = 1'b0;
   endtask

   task automatic pulse_hc(input logic [NV-1:0] vec, input int n, output int hc);
      bus.active_vfats_i = vec;
      tick(1);
      bus.active_vfats_i = '0;
      hc = 0;
      repeat (n) begin
         if (bus.ext_sbits_o[0]) hc++;
         tick(1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int hc;
      int c;
      reset_n_i          = 1'b0;
      bus.active_vfats_i = '0;
      bus.sbit_mode_i    = {NO{3'd6}};
      bus.sbit_sel_i     = '0;
      bus.stretch_i      = '0;
      bus.mult_thresh_i  = '0;
      bus.pulse_period_i = '0;
      bus.cnt_reset_i    = 1'b0;
      tick(3);
      chk("reset_sbits", 64'(bus.ext_sbits_o), 64'd0);
      chk("reset_cnt",   bus.ext_cnt_o, 64'd0);
      reset_n_i = 1'b1;
      tick(2);

      // Mode 0 single VFAT, 4-edge latency, one-cycle pulse; ch1 ORs everything.
      set_chan(0, 0, 5, 0);
      set_chan(1, 3, 0, 1);
      tick(4);
      bus.active_vfats_i = vb(5);
      tick(1);
      bus.active_vfats_i = '0;
      chk("lat_e1", 64'(bus.ext_sbits_o[0]), 64'd0);
      tick(1);
      chk("lat_e2", 64'(bus.ext_sbits_o[0]), 64'd0);
      tick(1);
      chk("lat_e3", 64'(bus.ext_sbits_o[0]), 64'd0);
      tick(1);
      chk("lat_e4", 64'(bus.ext_sbits_o[0]), 64'd1);
      tick(1);
      chk("lat_e5", 64'(bus.ext_sbits_o[0]), 64'd0);
      chk("m0_cnt", 64'(cnt_of(0)), 64'd1);
      chk("m3_cnt", 64'(cnt_of(1)), 64'd1);

      // Eta mode with stretch 3; second edge during HIGH is dropped.
      quiet();
      set_chan(0, 1, 2, 3);
      tick(3);
      clear_cnt();
      chk("clr_cnt", 64'(cnt_of(0)), 64'd0);
      bus.active_vfats_i = vb(18);
      tick(1);
      hc = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.ext_sbits_o[0]) hc++;
         bus.active_vfats_i = (i == 1) ? vb(10) : '0;
         tick(1);
      end
      chk("eta_len", 64'(hc), 64'd4);
      chk("eta_cnt", 64'(cnt_of(0)), 64'd1);

      // Multiplicity threshold.
      quiet();
      set_chan(0, 4, 0, 0);
      bus.mult_thresh_i = 5'd3;
      tick(4);
      clear_cnt();
      pulse_hc(vb(0) | vb(7), 8, hc);
      chk("mult_2of3", 64'(hc), 64'd0);
      pulse_hc(vb(0) | vb(7) | vb(23), 8, hc);
      chk("mult_3of3", 64'(hc), 64'd1);
      bus.mult_thresh_i = 5'd0;
      tick(3);
      pulse_hc('1, 8, hc);
      chk("mult_th0", 64'(hc), 64'd0);
      chk("mult_cnt", 64'(cnt_of(0)), 64'd1);

      // Test pulse generator.
      quiet();
      set_chan(0, 5, 0, 0);
      bus.pulse_period_i = 16'd9;
      tick(3);
      clear_cnt();
      tick(100);
      c = cnt_of(0);
      checks++;
      if (c < 9 || c > 11) begin
         errors++;
         $display("FAIL tp_count: got %0d expected 9..11", c);
      end
      bus.pulse_period_i = 16'd0;
      tick(5);
      clear_cnt();
      tick(50);
      chk("tp_period0", 64'(cnt_of(0)), 64'd0);

      // Saturation through mode toggling, then clear against live edges.
      quiet();
      clear_cnt();
      for (int i = 0; i < 2 * (CMAX + 1 + 5); i++) begin
         set_chan(0, (i % 2) ? 7 : 6, 0, 0);
         tick(1);
      end
      chk("sat_cnt", 64'(cnt_of(0)), 64'(CMAX));
      bus.cnt_reset_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_chan(0, (i % 2) ? 7 : 6, 0, 0);
         tick(1);
      end
      bus.cnt_reset_i = 1'b0;
      chk("clr_wins", 64'(cnt_of(0)), 64'd0);
      set_chan(0, 6, 0, 0);
      tick(4);
      clear_cnt();
      set_chan(0, 7, 0, 2);
      tick(20);
      chk("m7_once", 64'(cnt_of(0)), 64'd1);

      // Out-of-range sector select, valid sector on ch1.
      quiet();
      set_chan(0, 2, 31, 0);
      set_chan(1, 2, 5, 0);
      tick(3);
      clear_cnt();
      pulse_hc('1, 8, hc);
      chk("sel31_len", 64'(hc), 64'd0);
      chk("sel31_cnt", 64'(cnt_of(0)), 64'd0);
      chk("sect5_cnt", 64'(cnt_of(1)), 64'd1);

      // Reset mid-pulse, then re-arm on a raw level still high after release.
      quiet();
      set_chan(0, 0, 0, 15);
      tick(3);
      bus.active_vfats_i = vb(0);
      tick(1);
      bus.active_vfats_i = '0;
      tick(5);
      chk("pre_rst_high", 64'(bus.ext_sbits_o[0]), 64'd1);
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("rst_sbits", 64'(bus.ext_sbits_o), 64'd0);
      chk("rst_cnt",   bus.ext_cnt_o, 64'd0);
      bus.active_vfats_i = vb(0);
      tick(1);
      reset_n_i = 1'b1;
      tick(8);
      chk("rearm_cnt", 64'(cnt_of(0)), 64'd1);
      bus.active_vfats_i = '0;
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
